// File: rtl/ecc_core_arbiter_if.sv
// Requester/core-side bundle of the ECC core arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface ecc_core_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int KEY_W = 176,
  parameter int PT_W  = 163
);
  logic [NREQ-1:0]       i_req;
  logic [NREQ*KEY_W-1:0] i_key;
  logic [NREQ*PT_W-1:0]  i_basepoint;
  logic                  i_done_ECC;
  logic                  i_time_up;
  logic [NREQ-1:0]       o_gnt;
  logic [NREQ-1:0]       o_done;
  logic [NREQ-1:0]       o_err;
  logic                  o_start_ECC;
  logic                  o_en_ECC;
  logic [KEY_W-1:0]      o_key;
  logic [PT_W-1:0]       o_basepoint;

  modport slave (
    input  i_req, i_key, i_basepoint, i_done_ECC, i_time_up,
    output o_gnt, o_done, o_err, o_start_ECC, o_en_ECC, o_key, o_basepoint
  );

  modport master (
    output i_req, i_key, i_basepoint, i_done_ECC, i_time_up,
    input  o_gnt, o_done, o_err, o_start_ECC, o_en_ECC, o_key, o_basepoint
  );
endinterface

// File: rtl/ecc_core_arbiter.sv
// Round-robin owner of the shared ECC scalar-multiply core: latches the winner's
// operands, sequences start/enable, watches for a hung run and reports done/err.
module ecc_core_arbiter #(
  parameter int NREQ    = 2,
  parameter int KEY_W   = 176,
  parameter int PT_W    = 163,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic               clk,
  input  logic               rst,
  ecc_core_arbiter_if.slave  bus
);
  localparam int OW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4,
    ABORT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     rr_ptr;
  logic [CNT_W-1:0]  wd;
  logic [KEY_W-1:0]  key_q;
  logic [PT_W-1:0]   bp_q;
  logic [NREQ-1:0]   owner_oh;
  logic              wd_expired;

  logic [NREQ-1:0]   gnt_c;
  logic [NREQ-1:0]   done_c;
  logic [NREQ-1:0]   err_c;
  logic              start_c;
  logic              en_c;

  function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] p);
    return (p == OW'(NREQ - 1)) ? '0 : p + OW'(1);
  endfunction

  // Scan from the pointer upward with wrap; first requester found wins.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [OW-1:0]   ptr);
    logic [OW-1:0] idx;
    logic [OW-1:0] sel;
    logic          found;
    idx   = ptr;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = ptr_inc(idx);
    end
    return sel;
  endfunction

  assign owner_oh   = NREQ'(1) << owner;
  assign wd_expired = (wd == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A global abort wins over everything while the core is owned; FINISH and
  // ABORT already emit their pulse, so they always return to IDLE.
  always_comb begin
    state_nxt = state;
    gnt_c     = '0;
    done_c    = '0;
    err_c     = '0;
    start_c   = 1'b0;
    en_c      = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.i_req) state_nxt = LOAD;
      end
      LOAD: begin
        gnt_c     = owner_oh;
        state_nxt = bus.i_time_up ? ABORT : START;
      end
      START: begin
        gnt_c     = owner_oh;
        start_c   = 1'b1;
        en_c      = 1'b1;
        state_nxt = bus.i_time_up ? ABORT : RUN;
      end
      RUN: begin
        gnt_c = owner_oh;
        en_c  = 1'b1;
        if (bus.i_time_up)       state_nxt = ABORT;
        else if (bus.i_done_ECC) state_nxt = FINISH;
        else if (wd_expired)     state_nxt = ABORT;
      end
      FINISH: begin
        gnt_c     = owner_oh;
        done_c    = owner_oh;
        state_nxt = IDLE;
      end
      ABORT: begin
        gnt_c     = owner_oh;
        err_c     = owner_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= '0;
      rr_ptr <= '0;
      wd     <= '0;
      key_q  <= '0;
      bp_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.i_req) owner <= rr_pick(bus.i_req, rr_ptr);
        end
        LOAD: begin
          key_q <= bus.i_key[int'(owner)*KEY_W +: KEY_W];
          bp_q  <= bus.i_basepoint[int'(owner)*PT_W +: PT_W];
        end
        START:         wd     <= '0;
        RUN:           wd     <= wd + CNT_W'(1);
        FINISH, ABORT: rr_ptr <= ptr_inc(owner);
        default: ;
      endcase
    end
  end

  assign bus.o_gnt       = gnt_c;
  assign bus.o_done      = done_c;
  assign bus.o_err       = err_c;
  assign bus.o_start_ECC = start_c;
  assign bus.o_en_ECC    = en_c;
  assign bus.o_key       = key_q;
  assign bus.o_basepoint = bp_q;
endmodule

// File: tb/tb_ecc_core_arbiter.sv
// Directed bench for ecc_core_arbiter: a scoreboard of expected done/err pulses
// checked by a negedge monitor, plus latency and reset checks in the stimulus.
module tb_ecc_core_arbiter;
  localparam int NREQ  = 2;
  localparam int KEY_W = 176;
  localparam int PT_W  = 163;

  localparam logic [KEY_W-1:0] KEY0 = {11{16'hA5C3}};
  localparam logic [KEY_W-1:0] KEY1 = {11{16'h3C5A}};
  localparam logic [PT_W-1:0]  BP0  = {1'b1, {9{18'h15555}}};
  localparam logic [PT_W-1:0]  BP1  = {1'b0, {9{18'h2AAAA}}};

  typedef struct {
    int              dut;
    bit              is_err;
    logic [NREQ-1:0] gnt;
    logic [KEY_W-1:0] key;
    logic [PT_W-1:0]  bp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sbq[$];
  bit   ok;

  ecc_core_arbiter_if #(.NREQ(NREQ), .KEY_W(KEY_W), .PT_W(PT_W)) ia ();
  ecc_core_arbiter_if #(.NREQ(NREQ), .KEY_W(KEY_W), .PT_W(PT_W)) ib ();

  ecc_core_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W), .PT_W(PT_W), .TIMEOUT(64), .CNT_W(7))
    u_dut_a (.clk(clk), .rst(rst), .bus(ia));

  ecc_core_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W), .PT_W(PT_W), .TIMEOUT(8), .CNT_W(4))
    u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int d, input bit is_err, input logic [NREQ-1:0] g);
    exp_t e;
    e.dut    = d;
    e.is_err = is_err;
    e.gnt    = g;
    e.key    = g[1] ? KEY1 : KEY0;
    e.bp     = g[1] ? BP1 : BP0;
    sbq.push_back(e);
  endtask

  task automatic mon(input int d, input logic [NREQ-1:0] dn, input logic [NREQ-1:0] er,
                     input logic [NREQ-1:0] g, input logic [KEY_W-1:0] k,
                     input logic [PT_W-1:0] p);
    exp_t e;
    if (g != '0) chk("gnt_onehot", 256'($countones(g)), 256'(1));
    if ((dn | er) != '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 256'({dn, er}), 256'(0));
      end else begin
        e = sbq.pop_front();
        chk("pulse_dut", 256'(d), 256'(e.dut));
        chk("pulse_done", 256'(dn), 256'(e.is_err ? '0 : e.gnt));
        chk("pulse_err", 256'(er), 256'(e.is_err ? e.gnt : '0));
        chk("pulse_key", 256'(k), 256'(e.key));
        chk("pulse_bp", 256'(p), 256'(e.bp));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ia.o_done, ia.o_err, ia.o_gnt, ia.o_key, ia.o_basepoint);
    mon(1, ib.o_done, ib.o_err, ib.o_gnt, ib.o_key, ib.o_basepoint);
  end

  task automatic wait_start_a(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ia.o_start_ECC) found = 1'b1;
    end
    if (!found) chk("start_timeout", 256'(ia.o_start_ECC), 256'(1));
  endtask

  // Called in START; asserts done in the n-th RUN cycle, returns in FINISH.
  task automatic run_a(input int n);
    tick();
    for (int i = 1; i < n; i++) tick();
    ia.i_done_ECC = 1'b1;
    tick();
    ia.i_done_ECC = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    rst            = 1'b1;
    ia.i_req       = '0;
    ia.i_key       = {KEY1, KEY0};
    ia.i_basepoint = {BP1, BP0};
    ia.i_done_ECC  = 1'b0;
    ia.i_time_up   = 1'b0;
    ib.i_req       = '0;
    ib.i_key       = {KEY1, KEY0};
    ib.i_basepoint = {BP1, BP0};
    ib.i_done_ECC  = 1'b0;
    ib.i_time_up   = 1'b0;
    repeat (2) tick();
    chk("rst_gnt", 256'(ia.o_gnt), 256'(0));
    chk("rst_start", 256'(ia.o_start_ECC), 256'(0));
    chk("rst_en", 256'(ia.o_en_ECC), 256'(0));
    chk("rst_key", 256'(ia.o_key), 256'(0));
    chk("rst_bp", 256'(ia.o_basepoint), 256'(0));
    chk("rst_pulses", 256'({ia.o_done, ia.o_err}), 256'(0));
    chk("rst_gnt_b", 256'(ib.o_gnt), 256'(0));
    rst = 1'b0;
    tick();

    // done while idle is ignored
    ia.i_done_ECC = 1'b1;
    tick();
    ia.i_done_ECC = 1'b0;
    chk("idle_done_gnt", 256'(ia.o_gnt), 256'(0));
    chk("idle_done_en", 256'(ia.o_en_ECC), 256'(0));

    // single requester 0, done 10 cycles after start
    ia.i_req = 2'b01;
    expect_pulse(0, 1'b0, 2'b01);
    tick();
    chk("t1_gnt_t1", 256'(ia.o_gnt), 256'(2'b01));
    chk("t1_nostart_t1", 256'(ia.o_start_ECC), 256'(0));
    tick();
    chk("t1_start_t2", 256'(ia.o_start_ECC), 256'(1));
    chk("t1_en_t2", 256'(ia.o_en_ECC), 256'(1));
    chk("t1_key", 256'(ia.o_key), 256'(KEY0));
    chk("t1_bp", 256'(ia.o_basepoint), 256'(BP0));
    tick();
    chk("t1_start_pulse", 256'(ia.o_start_ECC), 256'(0));
    chk("t1_en_run", 256'(ia.o_en_ECC), 256'(1));
    for (int i = 2; i <= 10; i++) tick();
    ia.i_done_ECC = 1'b1;
    tick();
    ia.i_done_ECC = 1'b0;
    ia.i_req      = 2'b00;
    chk("t1_done", 256'(ia.o_done), 256'(2'b01));
    chk("t1_gnt_finish", 256'(ia.o_gnt), 256'(2'b01));
    chk("t1_en_finish", 256'(ia.o_en_ECC), 256'(0));
    tick();
    chk("t1_gnt_idle", 256'(ia.o_gnt), 256'(0));
    chk("t1_done_once", 256'(ia.o_done), 256'(0));

    // done during START is ignored, run continues until the real done
    ia.i_req = 2'b10;
    expect_pulse(0, 1'b0, 2'b10);
    wait_start_a(ok);
    ia.i_done_ECC = 1'b1;
    chk("t6_gnt", 256'(ia.o_gnt), 256'(2'b10));
    chk("t6_key", 256'(ia.o_key), 256'(KEY1));
    tick();
    ia.i_done_ECC = 1'b0;
    chk("t6_still_run", 256'(ia.o_en_ECC), 256'(1));
    chk("t6_no_done", 256'(ia.o_done), 256'(0));
    tick();
    tick();
    ia.i_done_ECC = 1'b1;
    tick();
    ia.i_done_ECC = 1'b0;
    ia.i_req      = 2'b00;
    chk("t6_done", 256'(ia.o_done), 256'(2'b10));
    tick();

    // both requesting: alternate 0,1,0,1
    ia.i_req = 2'b11;
    expect_pulse(0, 1'b0, 2'b01);
    expect_pulse(0, 1'b0, 2'b10);
    expect_pulse(0, 1'b0, 2'b01);
    expect_pulse(0, 1'b0, 2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_start_a(ok);
      chk("t2_order", 256'(ia.o_gnt), 256'((k % 2 == 0) ? 2'b01 : 2'b10));
      run_a(3);
    end
    ia.i_req = 2'b00;
    tick();

    // done and global abort together: abort wins, pointer still advances
    ia.i_req = 2'b01;
    expect_pulse(0, 1'b1, 2'b01);
    wait_start_a(ok);
    tick();
    tick();
    ia.i_done_ECC = 1'b1;
    ia.i_time_up  = 1'b1;
    tick();
    ia.i_done_ECC = 1'b0;
    ia.i_time_up  = 1'b0;
    ia.i_req      = 2'b00;
    chk("t4_err", 256'(ia.o_err), 256'(2'b01));
    chk("t4_no_done", 256'(ia.o_done), 256'(0));
    tick();
    tick();
    ia.i_req = 2'b11;
    expect_pulse(0, 1'b0, 2'b10);
    wait_start_a(ok);
    chk("t4_ptr_adv", 256'(ia.o_gnt), 256'(2'b10));
    run_a(2);
    ia.i_req = 2'b00;
    tick();

    // asynchronous reset in RUN
    ia.i_req = 2'b01;
    wait_start_a(ok);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_gnt", 256'(ia.o_gnt), 256'(0));
    chk("t5_en", 256'(ia.o_en_ECC), 256'(0));
    chk("t5_start", 256'(ia.o_start_ECC), 256'(0));
    chk("t5_key", 256'(ia.o_key), 256'(0));
    chk("t5_bp", 256'(ia.o_basepoint), 256'(0));
    chk("t5_pulses", 256'({ia.o_done, ia.o_err}), 256'(0));
    ia.i_req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    ia.i_req = 2'b10;
    expect_pulse(0, 1'b0, 2'b10);
    wait_start_a(ok);
    chk("t5_gnt_after", 256'(ia.o_gnt), 256'(2'b10));
    chk("t5_key_after", 256'(ia.o_key), 256'(KEY1));
    run_a(2);
    ia.i_req = 2'b00;
    tick();

    // watchdog on the TIMEOUT=8 instance
    ib.i_req = 2'b01;
    expect_pulse(1, 1'b1, 2'b01);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (ib.o_start_ECC) ok = 1'b1;
    end
    if (!ok) chk("t3_start_timeout", 256'(ib.o_start_ECC), 256'(1));
    tick();
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("t3_run_en", 256'(ib.o_en_ECC), 256'(1));
      chk("t3_no_early_err", 256'(ib.o_err), 256'(0));
    end
    tick();
    chk("t3_err", 256'(ib.o_err), 256'(2'b01));
    chk("t3_en_low", 256'(ib.o_en_ECC), 256'(0));
    chk("t3_no_done", 256'(ib.o_done), 256'(0));
    ib.i_req = 2'b00;
    tick();
    chk("t3_idle_gnt", 256'(ib.o_gnt), 256'(0));

    repeat (3) tick();
    chk("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
